// File: rtl/phv_queue_scheduler_pkg.sv
// Shared constants and types for the PHV queue scheduler.
// Widths here size the interface, the weight registers and the credit counter.
package phv_sched_pkg;

  localparam int PHV_LEN       = 32*64+256;
  localparam int NUM_QUEUES    = 4;
  localparam int WEIGHT_WIDTH  = 8;
  localparam int QID_WIDTH     = 2;
  localparam int PHV_QMASK_OFF = 141;

  typedef logic [QID_WIDTH-1:0]    qid_t;
  typedef logic [WEIGHT_WIDTH-1:0] weight_t;
  typedef logic [NUM_QUEUES-1:0]   qmask_t;

  function automatic qmask_t qid_onehot(input qid_t q);
    qid_onehot = qmask_t'(1) << q;
  endfunction

endpackage

// File: rtl/phv_queue_scheduler_if.sv
// Bundle between the four per-queue PHV FIFOs, the downstream consumer and the
// weight config port. The scheduler takes the slave side, its environment the master side.
interface phv_queue_scheduler_if;
  import phv_sched_pkg::*;

  logic [PHV_LEN-1:0] phv_in_0;
  logic [PHV_LEN-1:0] phv_in_1;
  logic [PHV_LEN-1:0] phv_in_2;
  logic [PHV_LEN-1:0] phv_in_3;
  logic               phv_in_valid_0;
  logic               phv_in_valid_1;
  logic               phv_in_valid_2;
  logic               phv_in_valid_3;
  logic               phv_rd_0;
  logic               phv_rd_1;
  logic               phv_rd_2;
  logic               phv_rd_3;

  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  qid_t               phv_out_qid;
  logic               ready_in;

  logic               cfg_wr;
  qid_t               cfg_qid;
  weight_t            cfg_weight;

  modport slave (
    input  phv_in_0, phv_in_1, phv_in_2, phv_in_3,
    input  phv_in_valid_0, phv_in_valid_1, phv_in_valid_2, phv_in_valid_3,
    output phv_rd_0, phv_rd_1, phv_rd_2, phv_rd_3,
    output phv_out, phv_out_valid, phv_out_qid,
    input  ready_in,
    input  cfg_wr, cfg_qid, cfg_weight
  );

  modport master (
    output phv_in_0, phv_in_1, phv_in_2, phv_in_3,
    output phv_in_valid_0, phv_in_valid_1, phv_in_valid_2, phv_in_valid_3,
    input  phv_rd_0, phv_rd_1, phv_rd_2, phv_rd_3,
    input  phv_out, phv_out_valid, phv_out_qid,
    output ready_in,
    output cfg_wr, cfg_qid, cfg_weight
  );

endinterface

// File: rtl/phv_queue_scheduler_picker.sv
// Rotating-priority encoder: first eligible queue in the order cur_q+1 .. cur_q.
// The current queue is checked last so a search always prefers moving on.
module rr_eligible_picker
  import phv_sched_pkg::*;
(
  input  qmask_t eligible,
  input  qid_t   cur_q,
  output logic   found,
  output qid_t   pick_q
);

  qid_t idx;

  always_comb begin
    found  = 1'b0;
    pick_q = cur_q;
    idx    = cur_q;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      idx = cur_q + qid_t'(i);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        pick_q = idx;
      end
    end
  end

endmodule

// File: rtl/phv_queue_scheduler.sv
// Weighted round-robin drain of four PHV FIFOs into one registered output slot.
// A queue keeps the grant while it has credit; otherwise the picker rotates to the next one.
module phv_queue_scheduler
  import phv_sched_pkg::*;
(
  input  logic                 axis_clk,
  input  logic                 aresetn,
  phv_queue_scheduler_if.slave sched
);

  logic [PHV_LEN-1:0] phv_in [NUM_QUEUES];
  qmask_t             in_valid;
  qmask_t             eligible;
  qmask_t             rd;

  weight_t            weight [NUM_QUEUES];
  qid_t               cur_q;
  weight_t            credit;

  logic [PHV_LEN-1:0] out_phv;
  qid_t               out_qid;
  logic               out_valid;

  logic               load_en;
  logic               cont;
  logic               found;
  logic               grant;
  qid_t               pick_q;
  qid_t               grant_q;

  assign phv_in[0] = sched.phv_in_0;
  assign phv_in[1] = sched.phv_in_1;
  assign phv_in[2] = sched.phv_in_2;
  assign phv_in[3] = sched.phv_in_3;
  assign in_valid  = {sched.phv_in_valid_3, sched.phv_in_valid_2,
                      sched.phv_in_valid_1, sched.phv_in_valid_0};

  assign load_en = ~out_valid | sched.ready_in;

  always_comb begin
    eligible = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      eligible[q] = in_valid[q] & (weight[q] != '0);
    end
  end

  rr_eligible_picker u_picker (
    .eligible (eligible),
    .cur_q    (cur_q),
    .found    (found),
    .pick_q   (pick_q)
  );

  // Reset gates the grant so no FIFO is popped while the slot is being cleared.
  always_comb begin
    cont    = eligible[cur_q] & (credit != '0);
    grant   = aresetn & load_en & (cont | found);
    grant_q = cont ? cur_q : pick_q;
    rd      = '0;
    if (grant) begin
      rd = qid_onehot(grant_q);
    end
  end

  assign sched.phv_rd_0 = rd[0];
  assign sched.phv_rd_1 = rd[1];
  assign sched.phv_rd_2 = rd[2];
  assign sched.phv_rd_3 = rd[3];

  // cur_q starts at 3 so the first search after reset begins at queue 0.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        weight[q] <= weight_t'(1);
      end
      cur_q     <= qid_t'(NUM_QUEUES - 1);
      credit    <= '0;
      out_phv   <= '0;
      out_qid   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (sched.cfg_wr) begin
        weight[sched.cfg_qid] <= sched.cfg_weight;
      end
      if (load_en) begin
        out_valid <= grant;
        if (grant) begin
          out_phv <= phv_in[grant_q];
          out_qid <= grant_q;
          if (cont) begin
            credit <= credit - weight_t'(1);
          end else begin
            cur_q  <= pick_q;
            credit <= weight[pick_q] - weight_t'(1);
          end
        end
      end
    end
  end

  assign sched.phv_out       = out_phv;
  assign sched.phv_out_qid   = out_qid;
  assign sched.phv_out_valid = out_valid;

endmodule

// File: tb/tb_phv_queue_scheduler.sv
// Directed bench for phv_queue_scheduler: a FIFO model feeds tagged PHVs and every
// grant is compared with a hand-derived queue order.
module tb_phv_queue_scheduler;
  import phv_sched_pkg::*;

  localparam int DEPTH = 64;
  localparam int REPS  = PHV_LEN / 64;

  logic axis_clk = 1'b0;
  logic aresetn;

  phv_queue_scheduler_if bus ();

  phv_queue_scheduler dut (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .sched    (bus)
  );

  always #5 axis_clk = ~axis_clk;

  logic [63:0] mem [NUM_QUEUES][DEPTH];
  int          wr_ptr [NUM_QUEUES] = '{default: 0};
  int          rd_ptr [NUM_QUEUES] = '{default: 0};
  int          push_seq [NUM_QUEUES] = '{default: 0};
  int          exp_seq [NUM_QUEUES] = '{default: 0};
  qmask_t      rd_vec;
  int          checks = 0;
  int          errors = 0;

  assign bus.phv_in_0 = {REPS{mem[0][rd_ptr[0]]}};
  assign bus.phv_in_1 = {REPS{mem[1][rd_ptr[1]]}};
  assign bus.phv_in_2 = {REPS{mem[2][rd_ptr[2]]}};
  assign bus.phv_in_3 = {REPS{mem[3][rd_ptr[3]]}};
  assign bus.phv_in_valid_0 = (wr_ptr[0] != rd_ptr[0]);
  assign bus.phv_in_valid_1 = (wr_ptr[1] != rd_ptr[1]);
  assign bus.phv_in_valid_2 = (wr_ptr[2] != rd_ptr[2]);
  assign bus.phv_in_valid_3 = (wr_ptr[3] != rd_ptr[3]);
  assign rd_vec = {bus.phv_rd_3, bus.phv_rd_2, bus.phv_rd_1, bus.phv_rd_0};

  always @(posedge axis_clk) begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (rd_vec[q]) rd_ptr[q] <= rd_ptr[q] + 1;
    end
  end

  function automatic logic [63:0] phv_word(input int q, input int s);
    return {8'hA5, 24'h0, 8'(q), 8'h0, 16'(s)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pushes n tagged PHVs into queue q's FIFO model.
  task automatic applyStimulus(input int q, input int n);
    for (int i = 0; i < n; i++) begin
      mem[q][wr_ptr[q]] = phv_word(q, push_seq[q]);
      push_seq[q]++;
      wr_ptr[q]++;
    end
  endtask

  task automatic expect_grant(input int q);
    @(posedge axis_clk);
    @(negedge axis_clk);
    checkOutput("out_valid", 64'(bus.phv_out_valid), 64'd1);
    checkOutput("out_qid", 64'(bus.phv_out_qid), 64'(q));
    checkOutput("out_phv_lo", bus.phv_out[63:0], phv_word(q, exp_seq[q]));
    checkOutput("out_phv_hi", bus.phv_out[PHV_LEN-1 -: 64], phv_word(q, exp_seq[q]));
    exp_seq[q]++;
  endtask

  task automatic expect_idle();
    @(posedge axis_clk);
    @(negedge axis_clk);
    checkOutput("idle_valid", 64'(bus.phv_out_valid), 64'd0);
    checkOutput("idle_rd", 64'(rd_vec), 64'd0);
  endtask

  task automatic write_weight(input int q, input int w);
    bus.cfg_wr     = 1'b1;
    bus.cfg_qid    = qid_t'(q);
    bus.cfg_weight = weight_t'(w);
    @(posedge axis_clk);
    @(negedge axis_clk);
    bus.cfg_wr = 1'b0;
  endtask

  initial begin
    int pat2 [7];
    pat2 = '{0, 0, 0, 1, 2, 2, 3};
    aresetn        = 1'b0;
    bus.ready_in   = 1'b1;
    bus.cfg_wr     = 1'b0;
    bus.cfg_qid    = '0;
    bus.cfg_weight = '0;
    repeat (2) @(negedge axis_clk);
    checkOutput("rst_valid", 64'(bus.phv_out_valid), 64'd0);
    checkOutput("rst_qid", 64'(bus.phv_out_qid), 64'd0);
    checkOutput("rst_phv", bus.phv_out[63:0], 64'd0);
    checkOutput("rst_rd", 64'(rd_vec), 64'd0);
    aresetn = 1'b1;

    $display("[TB] default weights, plain round robin");
    for (int q = 0; q < NUM_QUEUES; q++) applyStimulus(q, 3);
    #1;
    checkOutput("first_rd", 64'(rd_vec), 64'b0001);
    for (int i = 0; i < 12; i++) expect_grant(i % 4);
    expect_idle();

    $display("[TB] weights 3,1,2,1");
    write_weight(0, 3);
    write_weight(1, 1);
    write_weight(2, 2);
    write_weight(3, 1);
    applyStimulus(0, 6);
    applyStimulus(1, 2);
    applyStimulus(2, 4);
    applyStimulus(3, 2);
    for (int i = 0; i < 14; i++) expect_grant(pat2[i % 7]);
    expect_idle();

    $display("[TB] weights 2,2,2,2, single busy queue then q0 joins at zero credit");
    for (int q = 0; q < NUM_QUEUES; q++) write_weight(q, 2);
    applyStimulus(2, 5);
    for (int i = 0; i < 5; i++) expect_grant(2);
    applyStimulus(2, 2);
    applyStimulus(0, 1);
    expect_grant(2);
    expect_grant(0);
    expect_grant(2);
    expect_idle();

    $display("[TB] backpressure holding a q1 PHV");
    applyStimulus(1, 3);
    expect_grant(1);
    bus.ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge axis_clk);
      @(negedge axis_clk);
      checkOutput("hold_valid", 64'(bus.phv_out_valid), 64'd1);
      checkOutput("hold_qid", 64'(bus.phv_out_qid), 64'd1);
      checkOutput("hold_phv", bus.phv_out[63:0], phv_word(1, exp_seq[1] - 1));
      checkOutput("hold_rd", 64'(rd_vec), 64'd0);
    end
    bus.ready_in = 1'b1;
    #1;
    checkOutput("release_rd", 64'(rd_vec), 64'b0010);
    expect_grant(1);
    expect_grant(1);
    expect_idle();

    $display("[TB] disabling q1 mid-credit");
    write_weight(1, 4);
    applyStimulus(1, 6);
    expect_grant(1);
    expect_grant(1);
    expect_grant(1);
    applyStimulus(3, 2);
    bus.cfg_wr     = 1'b1;
    bus.cfg_qid    = 2'd1;
    bus.cfg_weight = '0;
    expect_grant(1);
    bus.cfg_wr = 1'b0;
    expect_grant(3);
    expect_grant(3);
    expect_idle();
    expect_idle();
    write_weight(1, 1);
    checkOutput("reenable_valid", 64'(bus.phv_out_valid), 64'd0);
    expect_grant(1);
    expect_grant(1);
    expect_idle();

    $display("[TB] reset mid-burst on q3");
    write_weight(3, 4);
    applyStimulus(3, 5);
    applyStimulus(0, 3);
    expect_grant(3);
    expect_grant(3);
    aresetn = 1'b0;
    #1;
    checkOutput("rst_burst_rd", 64'(rd_vec), 64'd0);
    @(posedge axis_clk);
    @(negedge axis_clk);
    checkOutput("rst_burst_valid", 64'(bus.phv_out_valid), 64'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) expect_grant((i % 2 == 0) ? 0 : 3);
    expect_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
